// File: rtl/switch_debounce_sync.sv
// Slide-switch front end: 2-flop synchronizer, per-bit stability-count debouncer and rise/fall strobes.
// Optional macro SW_TOGGLE_EN adds a per-bit toggle latch driven by sw_rise; otherwise sw_toggle is 0.
module switch_debounce_sync #(
  parameter int N_SW          = 4,
  parameter int STABLE_CYCLES = 1_000_000
) (
  input  logic            CLK100MHZ,
  input  logic            rst,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_db,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic [N_SW-1:0] sw_toggle
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [N_SW-1:0]  sync_p0;
  logic [N_SW-1:0]  sync_p1;
  logic [CNT_W-1:0] cnt_p2 [N_SW];

  function automatic logic cnt_done(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_MAX);
  endfunction

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      sw_db   <= '0;
      sw_rise <= '0;
      sw_fall <= '0;
      for (int i = 0; i < N_SW; i++) cnt_p2[i] <= '0;
    end else begin
      // p0/p1: two-flop synchronizer, nothing in between
      sync_p0 <= sw_raw;
      sync_p1 <= sync_p0;
      // p2: stability counter; any agreeing cycle restarts the count
      for (int i = 0; i < N_SW; i++) begin
        if (sync_p1[i] == sw_db[i]) begin
          cnt_p2[i]  <= '0;
          sw_rise[i] <= 1'b0;
          sw_fall[i] <= 1'b0;
        end else if (cnt_done(cnt_p2[i])) begin
          cnt_p2[i]  <= '0;
          sw_db[i]   <= sync_p1[i];
          sw_rise[i] <= sync_p1[i];
          sw_fall[i] <= ~sync_p1[i];
        end else begin
          cnt_p2[i]  <= cnt_p2[i] + CNT_W'(1);
          sw_rise[i] <= 1'b0;
          sw_fall[i] <= 1'b0;
        end
      end
    end
  end

`ifdef SW_TOGGLE_EN
  always_ff @(posedge CLK100MHZ) begin
    if (rst) sw_toggle <= '0;
    else     sw_toggle <= sw_toggle ^ sw_rise;
  end
`else
  assign sw_toggle = '0;
`endif

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Directed bench for switch_debounce_sync with STABLE_CYCLES=8, N_SW=4.
// Table of level/hold/expect records plus hand sequences for latency, bounce, reset and toggle cases.
module tb_switch_debounce_sync;

  localparam int N_SW = 4;
  localparam int STABLE_CYCLES = 8;
  localparam int LAT = STABLE_CYCLES + 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_SW-1:0] sw_raw;
  logic [N_SW-1:0] sw_db;
  logic [N_SW-1:0] sw_rise;
  logic [N_SW-1:0] sw_fall;
  logic [N_SW-1:0] sw_toggle;

  int checks = 0;
  int failures = 0;
  int rise_cnt [N_SW];
  int fall_cnt [N_SW];
  int both_cnt = 0;
  int tog_nz_cnt = 0;

  switch_debounce_sync #(.N_SW(N_SW), .STABLE_CYCLES(STABLE_CYCLES)) dut (
    .CLK100MHZ(clk),
    .rst(rst),
    .sw_raw(sw_raw),
    .sw_db(sw_db),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .sw_toggle(sw_toggle)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < N_SW; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N_SW; i++) begin
      if (sw_rise[i] === 1'b1) rise_cnt[i]++;
      if (sw_fall[i] === 1'b1) fall_cnt[i]++;
    end
    if ((sw_rise & sw_fall) !== 4'h0) both_cnt++;
    if (sw_toggle !== 4'h0) tog_nz_cnt++;
  end

  typedef struct {
    logic [3:0] raw;
    int         cycles;
    logic [3:0] db;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t tbl [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Called right after the edge following the stimulus change: the change lands on edge LAT.
  task automatic expect_edge(input string name, input logic [3:0] db_old, input logic [3:0] db_new,
                             input logic [3:0] rise, input logic [3:0] fall);
    for (int i = 1; i < LAT; i++) begin
      step();
      chk({name, "_db_hold"}, sw_db, db_old);
      chk({name, "_rise_quiet"}, sw_rise, 4'h0);
      chk({name, "_fall_quiet"}, sw_fall, 4'h0);
    end
    step();
    chk({name, "_db_new"}, sw_db, db_new);
    chk({name, "_rise"}, sw_rise, rise);
    chk({name, "_fall"}, sw_fall, fall);
    step();
    chk({name, "_db_after"}, sw_db, db_new);
    chk({name, "_rise_end"}, sw_rise, 4'h0);
    chk({name, "_fall_end"}, sw_fall, 4'h0);
  endtask

  initial begin
    int snap0, snap1r, snap1f;
    logic [3:0] tog_exp;

    tbl[0] = '{raw: 4'h1, cycles: 7,  db: 4'h0, rise: 4'h0, fall: 4'h0};
    tbl[1] = '{raw: 4'h0, cycles: 12, db: 4'h0, rise: 4'h0, fall: 4'h0};
    tbl[2] = '{raw: 4'hA, cycles: 9,  db: 4'h0, rise: 4'h0, fall: 4'h0};
    tbl[3] = '{raw: 4'hA, cycles: 1,  db: 4'hA, rise: 4'hA, fall: 4'h0};
    tbl[4] = '{raw: 4'hA, cycles: 1,  db: 4'hA, rise: 4'h0, fall: 4'h0};
    tbl[5] = '{raw: 4'h0, cycles: 9,  db: 4'hA, rise: 4'h0, fall: 4'h0};
    tbl[6] = '{raw: 4'h0, cycles: 1,  db: 4'h0, rise: 4'h0, fall: 4'hA};
    tbl[7] = '{raw: 4'h0, cycles: 1,  db: 4'h0, rise: 4'h0, fall: 4'h0};

    // Reset with switches held high, then the rise after release
    rst = 1'b1;
    sw_raw = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_db", sw_db, 4'h0);
      chk("rst_rise", sw_rise, 4'h0);
      chk("rst_fall", sw_fall, 4'h0);
      chk("rst_toggle", sw_toggle, 4'h0);
    end
    rst = 1'b0;
    expect_edge("t1_rise", 4'h0, 4'hF, 4'hF, 4'h0);
    sw_raw = 4'h0;
    expect_edge("t1_fall", 4'hF, 4'h0, 4'h0, 4'hF);

    // Table: 7-cycle pulse rejected, then simultaneous multi-bit rise/fall
    snap0 = rise_cnt[0];
    for (int r = 0; r < 8; r++) begin
      sw_raw = tbl[r].raw;
      for (int c = 0; c < tbl[r].cycles; c++) step();
      chk($sformatf("tbl%0d_db", r), sw_db, tbl[r].db);
      chk($sformatf("tbl%0d_rise", r), sw_rise, tbl[r].rise);
      chk($sformatf("tbl%0d_fall", r), sw_fall, tbl[r].fall);
    end
    chk_int("t2_short_pulse_rise0", rise_cnt[0] - snap0, 0);

    // 8-cycle pulse on bit 0 is just long enough
    snap0 = rise_cnt[0];
    sw_raw = 4'h1;
    repeat (8) step();
    sw_raw = 4'h0;
    step();
    chk("t2_pulse8_db_e9", sw_db, 4'h0);
    chk("t2_pulse8_rise_e9", sw_rise, 4'h0);
    step();
    chk("t2_pulse8_db_e10", sw_db, 4'h1);
    chk("t2_pulse8_rise_e10", sw_rise, 4'h1);
    repeat (7) step();
    chk("t2_pulse8_db_e17", sw_db, 4'h1);
    step();
    chk("t2_pulse8_db_e18", sw_db, 4'h0);
    chk("t2_pulse8_fall_e18", sw_fall, 4'h1);
    chk_int("t2_pulse8_rise_count", rise_cnt[0] - snap0, 1);

    // Bounce on bit 1 then settle high
    snap1r = rise_cnt[1];
    snap1f = fall_cnt[1];
    for (int k = 0; k < 4; k++) begin
      sw_raw = (k % 2 == 0) ? 4'h2 : 4'h0;
      repeat (3) step();
    end
    sw_raw = 4'h2;
    expect_edge("t3_bounce", 4'h0, 4'h2, 4'h2, 4'h0);
    chk_int("t3_rise_count", rise_cnt[1] - snap1r, 1);
    chk_int("t3_fall_count", fall_cnt[1] - snap1f, 0);
    sw_raw = 4'h0;
    expect_edge("t3_release", 4'h2, 4'h0, 4'h0, 4'h2);

    // Reset mid-count on bit 2 discards progress
    sw_raw = 4'h4;
    repeat (7) step();
    rst = 1'b1;
    step();
    chk("t5_rst_db", sw_db, 4'h0);
    chk("t5_rst_rise", sw_rise, 4'h0);
    rst = 1'b0;
    expect_edge("t5_rise", 4'h0, 4'h4, 4'h4, 4'h0);
    sw_raw = 4'h0;
    expect_edge("t5_fall", 4'h4, 4'h0, 4'h0, 4'h4);

    // Toggle latch on bit 3 across three press/release cycles
    rst = 1'b1;
    step();
    chk("t6_rst_toggle", sw_toggle, 4'h0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
`ifdef SW_TOGGLE_EN
      tog_exp = (k % 2 == 0) ? 4'h8 : 4'h0;
`else
      tog_exp = 4'h0;
`endif
      sw_raw = 4'h8;
      expect_edge($sformatf("t6_press%0d", k), 4'h0, 4'h8, 4'h8, 4'h0);
      chk($sformatf("t6_toggle_press%0d", k), sw_toggle, tog_exp);
      sw_raw = 4'h0;
      expect_edge($sformatf("t6_release%0d", k), 4'h8, 4'h0, 4'h0, 4'h8);
      chk($sformatf("t6_toggle_release%0d", k), sw_toggle, tog_exp);
    end

    chk_int("rise_fall_overlap_cycles", both_cnt, 0);
`ifndef SW_TOGGLE_EN
    chk_int("toggle_nonzero_cycles", tog_nz_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
